ram_sequencer: RTL and testbench

RAM_SEQUENCER -- requirements
Module: ram_sequencer

---
 rtl/ram_seq_pkg.sv | 23 ++
 rtl/ram_seq_addr_gen.sv | 40 ++++
 rtl/ram_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ram_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared types for the RAM sequencer.
// Holds op encodings, FSM state type and default widths.
package ram_seq_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_READ     = 2'd0,
    OP_FILL     = 2'd1,
    OP_FILL_INC = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_seq_addr_gen.sv
// ram_seq_addr_gen: block address counter (wraps mod 2^ADDR_W)
// and remaining-length counter. Ports: load_i/start_i/len_i
// start a block, step_i advances, next_o is the following
// address, done_o flags that the current word is the last.
module ram_seq_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] next_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;

  // A zero length encodes a full sweep of the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= start_i;
      rem_q  <= (len_i == '0)
              ? {1'b1, {ADDR_W{1'b0}}}
              : {1'b0, len_i};
    end else if (step_i) begin
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  assign next_o = addr_q + 1'b1;
  assign done_o = (rem_q == (ADDR_W+1)'(1));

endmodule

// File: rtl/ram_sequencer.sv
// ram_sequencer: command-driven FILL / READ sequencer for a
// single-port RAM with one-cycle read latency.
// Ports: cmd_* command handshake, rsp_* read-word stream,
// ram_* registered RAM drive / ram_q read data, busy,
// cmd_err reserved-op pulse, checksum of words read.
// Macro RAM_SEQ_CHECKSUM_EN enables the checksum adder;
// otherwise checksum is tied to 0.
module ram_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              cmd_err,
  output logic              busy,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  state_e state_q, state_d;
  op_e    op;

  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_err_q, cmd_err_d;
  logic              incr_q, incr_d;

  logic              ag_load, ag_step, ag_done;
  logic [ADDR_W-1:0] ag_next;

  assign op = op_e'(cmd_op);

  ram_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ag_load),
    .step_i  (ag_step),
    .start_i (cmd_addr),
    .len_i   (cmd_len),
    .next_o  (ag_next),
    .done_o  (ag_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      cmd_err_q   <= 1'b0;
      incr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      cmd_err_q   <= cmd_err_d;
      incr_q      <= incr_d;
    end
  end

  // The RAM address is registered as a block enters RD_ISSUE,
  // so ram_q is valid in RD_WAIT: three cycles per read word.
  // Writes raise ram_we on entry to WR, so it is high for
  // exactly the cycles spent in WR.
  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_data_d  = rsp_data_q;
    cmd_err_d   = 1'b0;
    incr_d      = incr_q;
    ag_load     = 1'b0;
    ag_step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (op)
            OP_READ: begin
              ag_load    = 1'b1;
              ram_addr_d = cmd_addr;
              state_d    = RD_ISSUE;
            end
            OP_FILL, OP_FILL_INC: begin
              ag_load    = 1'b1;
              ram_addr_d = cmd_addr;
              ram_data_d = cmd_data;
              ram_we_d   = 1'b1;
              incr_d     = (op == OP_FILL_INC);
              state_d    = WR;
            end
            OP_RSVD: begin
              cmd_err_d = 1'b1;
            end
          endcase
        end
      end
      WR: begin
        if (ag_done) begin
          state_d = IDLE;
        end else begin
          ag_step    = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = ag_next;
          ram_data_d = ram_data_q + DATA_W'(incr_q);
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_data_d  = ram_q;
        rsp_valid_d = 1'b1;
        rsp_last_d  = ag_done;
        state_d     = RD_HOLD;
      end
      RD_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (ag_done) begin
            state_d = IDLE;
          end else begin
            ag_step    = 1'b1;
            ram_addr_d = ag_next;
            state_d    = RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef RAM_SEQ_CHECKSUM_EN
  logic              csum_clr, csum_add;
  logic [DATA_W-1:0] csum_q;

  assign csum_clr = (state_q == IDLE) && cmd_valid
                  && (op == OP_READ);
  assign csum_add = (state_q == RD_HOLD) && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (csum_clr) begin
      csum_q <= '0;
    end else if (csum_add) begin
      csum_q <= csum_q + rsp_data_q;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// tb_ram_sequencer: directed bench for ram_sequencer with a
// behavioural single-port RAM (one-cycle registered read).
module tb_ram_sequencer;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          cmd_err;
  logic          busy;
  logic [DW-1:0] checksum;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [64];
  int            wcnt = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  ram_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .cmd_err   (cmd_err),
    .busy      (busy),
    .checksum  (checksum),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_data  (ram_data),
    .ram_q     (ram_q)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      wcnt = wcnt + 1;
    end
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [AW-1:0] a,
                       input logic [AW-1:0] l,
                       input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 200) begin
      step();
      c++;
    end
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, w0;
    logic [AW-1:0] ea;
    logic acc;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", cmd_ready, 1);

    // FILL constant across the wrap point.
    issue(2'd1, 6'h3E, 6'd4, 8'hA5);
    ea = 6'h3E;
    for (int i = 0; i < 4; i++) begin
      chk("fill_we", ram_we, 1);
      chk("fill_addr", ram_addr, ea);
      chk("fill_data", ram_data, 8'hA5);
      chk("fill_ready", cmd_ready, 0);
      ea = ea + 1'b1;
      step();
    end
    chk("fill_end_we", ram_we, 0);
    chk("fill_end_busy", busy, 0);
    chk("fill_mem3f", mem[63], 8'hA5);
    chk("fill_mem01", mem[1], 8'hA5);

    // FILL incrementing, len 0 = 64 words.
    w0 = wcnt;
    issue(2'd2, 6'h00, 6'd0, 8'hF0);
    wait_idle();
    chk("inc_count", wcnt - w0, 64);
    chk("inc_mem0", mem[0], 8'hF0);
    chk("inc_mem15", mem[15], 8'hFF);
    chk("inc_mem16", mem[16], 8'h00);
    chk("inc_mem63", mem[63], 8'h2F);

    // READ 5..7 with a 4-cycle stall on word 2.
    issue(2'd0, 6'd5, 6'd3, 8'h00);
    chk("rd_busy", busy, 1);
    wait_rsp(n);
    chk("rd_w1_data", rsp_data, 8'hF5);
    chk("rd_w1_last", rsp_last, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    wait_rsp(n);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 8'hF6);
      chk("stall_last", rsp_last, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    wait_rsp(n);
    chk("rd_w3_data", rsp_data, 8'hF7);
    chk("rd_w3_last", rsp_last, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_done_valid", rsp_valid, 0);
    chk("rd_done_busy", busy, 0);
`ifdef RAM_SEQ_CHECKSUM_EN
    chk("rd_checksum", checksum, 8'hE2);
`else
    chk("rd_checksum_off", checksum, 8'h00);
`endif

    // Reserved opcode.
    w0 = wcnt;
    issue(2'd3, 6'd9, 6'd2, 8'h55);
    chk("err_pulse", cmd_err, 1);
    chk("err_busy", busy, 0);
    chk("err_we", ram_we, 0);
    step();
    chk("err_clear", cmd_err, 0);
    chk("err_busy2", busy, 0);
    chk("err_nowrite", wcnt - w0, 0);

    // Reset in the 10th cycle of a 20-word FILL.
    w0 = wcnt;
    issue(2'd1, 6'd10, 6'd20, 8'h3C);
    repeat (9) step();
    chk("abort_we_pre", ram_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_writes", wcnt - w0, 9);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_ready", cmd_ready, 1);
    repeat (5) step();
    chk("abort_nomore", wcnt - w0, 9);
    chk("abort_we_post", ram_we, 0);

    // Back-to-back FILL then READ, cmd_valid held.
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_addr  = 6'h20;
    cmd_len   = 6'd8;
    cmd_data  = 8'h11;
    step();
    cmd_op   = 2'd0;
    cmd_data = 8'h00;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      if (cmd_ready) acc = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    chk("b2b_accept", acc, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_rsp(n);
      if (i > 0) chk("b2b_rate", n, 2);
      chk("b2b_data", rsp_data, 8'h11 + i);
      chk("b2b_last", rsp_last, (i == 7));
      step();
    end
    rsp_ready = 1'b0;
    chk("b2b_busy", busy, 0);
`ifdef RAM_SEQ_CHECKSUM_EN
    chk("b2b_checksum", checksum, 8'hA4);
`else
    chk("b2b_checksum_off", checksum, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
